// File: rtl/cuca2_core.sv
// cuca2_core: two-word accumulator CPU with ALU flags, conditional branch and req/ack memory port
// Ports:
//   clock, n_reset       clock and synchronous active-low reset
//   mem_req/we/addr/wdata registered memory request, held until mem_ack
//   mem_rdata, mem_ack   read data and completion, sampled together
//   halted, illegal      core stopped; sticky undefined-opcode flag
//   acc_out, pc_out      accumulator and program counter
//   flags_out            {carry, zero}
//   ext_bus              last word moved on the memory data path
module cuca2_core #(
  parameter int BITW = 8,
  parameter int ADDRW = 8,
  parameter logic [ADDRW-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             n_reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [BITW-1:0]  mem_wdata,
  input  logic [BITW-1:0]  mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic             illegal,
  output logic [BITW-1:0]  acc_out,
  output logic [ADDRW-1:0] pc_out,
  output logic [1:0]       flags_out,
  output logic [BITW-1:0]  ext_bus
);
  typedef enum logic [2:0] {FETCH_OP, DECODE, FETCH_ARG, EXEC_MEM, HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'd1, OP_STA = 4'd2, OP_ADD = 4'd3, OP_SUB = 4'd4,
                         OP_AND = 4'd5, OP_JMP = 4'd6, OP_JZ = 4'd7, OP_LDI = 4'd8, OP_HLT = 4'd9;
  state_t state_q, state_d;
  logic [ADDRW-1:0] pc_q, pc_d, opnd_q, opnd_d, addr_q, addr_d;
  logic [BITW-1:0] acc_q, acc_d, wdata_q, wdata_d, ext_q, ext_d, res;
  logic [3:0] ir_q, ir_d;
  logic zero_q, zero_d, carry_q, carry_d, req_q, req_d, we_q, we_d, ill_q, ill_d;
  logic [BITW:0] sum, diff;
  logic [ADDRW-1:0] rd_addr;
  logic ack, bad_op, mem_op;
  assign sum = {1'b0, acc_q} + {1'b0, mem_rdata};
  assign diff = {1'b0, acc_q} - {1'b0, mem_rdata};
  assign rd_addr = mem_rdata[ADDRW-1:0];
  assign ack = req_q & mem_ack;
  assign bad_op = ir_q > OP_HLT;
  assign mem_op = ir_q inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND};
  // A fresh request is raised in the first cycle of each memory state, so
  // every access is preceded by at least one idle cycle.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    opnd_d = opnd_q;
    addr_d = addr_q;
    acc_d = acc_q;
    wdata_d = wdata_q;
    ext_d = ext_q;
    ir_d = ir_q;
    zero_d = zero_q;
    carry_d = carry_q;
    req_d = req_q;
    we_d = we_q;
    ill_d = ill_q;
    res = ir_q == OP_ADD ? sum[BITW-1:0] :
          ir_q == OP_SUB ? diff[BITW-1:0] :
          ir_q == OP_AND ? (acc_q & mem_rdata) : mem_rdata;
    case (state_q)
      FETCH_OP: begin
        if (!req_q) begin
          req_d = 1'b1;
          we_d = 1'b0;
          addr_d = pc_q;
        end else if (ack) begin
          req_d = 1'b0;
          ir_d = mem_rdata[3:0];
          ext_d = mem_rdata;
          pc_d = pc_q + ADDRW'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        ill_d = ill_q | bad_op;
        state_d = (ir_q == OP_HLT || bad_op) ? HALT : FETCH_ARG;
      end
      FETCH_ARG: begin
        if (!req_q) begin
          req_d = 1'b1;
          we_d = 1'b0;
          addr_d = pc_q;
        end else if (ack) begin
          req_d = 1'b0;
          opnd_d = rd_addr;
          ext_d = mem_rdata;
          acc_d = ir_q == OP_LDI ? mem_rdata : acc_q;
          zero_d = ir_q == OP_LDI ? mem_rdata == '0 : zero_q;
          // A taken jump replaces the operand-fetch increment.
          pc_d = (ir_q == OP_JMP || (ir_q == OP_JZ && zero_q)) ? rd_addr : pc_q + ADDRW'(1);
          state_d = mem_op ? EXEC_MEM : FETCH_OP;
        end
      end
      EXEC_MEM: begin
        if (!req_q) begin
          req_d = 1'b1;
          we_d = ir_q == OP_STA;
          addr_d = opnd_q;
          wdata_d = acc_q;
        end else if (ack) begin
          req_d = 1'b0;
          ext_d = we_q ? wdata_q : mem_rdata;
          acc_d = we_q ? acc_q : res;
          zero_d = we_q ? zero_q : res == '0;
          // Borrow is the inverted carry of the extended subtraction: set when acc < mem.
          carry_d = ir_q == OP_ADD ? sum[BITW] : ir_q == OP_SUB ? diff[BITW] : carry_q;
          state_d = FETCH_OP;
        end
      end
      default: req_d = 1'b0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= FETCH_OP;
      pc_q <= RESET_PC;
      opnd_q <= '0;
      addr_q <= '0;
      acc_q <= '0;
      wdata_q <= '0;
      ext_q <= '0;
      ir_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      opnd_q <= opnd_d;
      addr_q <= addr_d;
      acc_q <= acc_d;
      wdata_q <= wdata_d;
      ext_q <= ext_d;
      ir_q <= ir_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      req_q <= req_d;
      we_q <= we_d;
      ill_q <= ill_d;
    end
  end
  assign mem_req = req_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign halted = state_q == HALT;
  assign illegal = ill_q;
  assign acc_out = acc_q;
  assign pc_out = pc_q;
  assign flags_out = {carry_q, zero_q};
  assign ext_bus = ext_q;
endmodule

// File: tb/tb_cuca2_core.sv
// tb_cuca2_core: directed program vectors plus handshake, reset and address-wrap sequences
module tb_cuca2_core;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic n_reset = 1'b0, n_reset4 = 1'b0;
  logic mem_req, mem_we, mem_ack = 1'b0, halted, illegal;
  logic [7:0] mem_addr, mem_wdata, mem_rdata = '0, acc_out, pc_out, ext_bus;
  logic [1:0] flags_out;
  logic req4, we4, ack4 = 1'b0, halted4, illegal4;
  logic [3:0] addr4, pc4;
  logic [7:0] wdata4, rdata4 = '0, acc4, ext4;
  logic [1:0] flags4;
  cuca2_core dut (.clock(clock), .n_reset(n_reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halted(halted), .illegal(illegal), .acc_out(acc_out), .pc_out(pc_out),
    .flags_out(flags_out), .ext_bus(ext_bus));
  cuca2_core #(.BITW(8), .ADDRW(4)) dut4 (.clock(clock), .n_reset(n_reset4), .mem_req(req4),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4), .mem_rdata(rdata4), .mem_ack(ack4),
    .halted(halted4), .illegal(illegal4), .acc_out(acc4), .pc_out(pc4),
    .flags_out(flags4), .ext_bus(ext4));
  logic [7:0] mem [256];
  logic [7:0] mem4 [16];
  logic [3:0] trace [$];
  int ws = 0, wcnt = 0;
  int n_chk = 0, n_bad = 0;
  // Memory responders: ack after ws idle counts, presented on the falling edge.
  always @(negedge clock) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (!mem_ack) begin
      if (wcnt == ws) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else wcnt++;
    end
  end
  always @(negedge clock) begin
    if (!req4) ack4 = 1'b0;
    else if (!ack4) begin
      ack4 = 1'b1;
      rdata4 = mem4[addr4];
      trace.push_back(addr4);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 400) begin
      step(1);
      cyc++;
    end
  endtask
  typedef struct packed {
    logic [95:0] prog;
    logic [7:0] a1, v1, a2, v2, wst, acc, pc;
    logic [1:0] fl;
    logic ill;
  } vec_t;
  vec_t tv [11];
  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = 8'h09;
    for (int i = 0; i < 12; i++) mem[i] = v.prog[95-8*i -: 8];
    mem[v.a1] = v.v1;
    mem[v.a2] = v.v2;
    ws = int'(v.wst);
  endtask
  initial begin
    int cyc, ok;
    tv[0]  = '{96'h080509090909090909090909, 8'h20, 8'h00, 8'h20, 8'h00, 8'd0, 8'h05, 8'h03, 2'b00, 1'b0};
    tv[1]  = '{96'h082003200909090909090909, 8'h20, 8'hF0, 8'h20, 8'hF0, 8'd0, 8'h10, 8'h05, 2'b10, 1'b0};
    tv[2]  = '{96'h080304210909090909090909, 8'h21, 8'h03, 8'h21, 8'h03, 8'd0, 8'h00, 8'h05, 2'b01, 1'b0};
    tv[3]  = '{96'h080007100909090909090909, 8'h10, 8'h09, 8'h10, 8'h09, 8'd0, 8'h00, 8'h11, 2'b01, 1'b0};
    tv[4]  = '{96'h080107100909090909090909, 8'h10, 8'h09, 8'h10, 8'h09, 8'd0, 8'h01, 8'h05, 2'b00, 1'b0};
    tv[5]  = '{96'h0C0909090909090909090909, 8'h20, 8'h00, 8'h20, 8'h00, 8'd0, 8'h00, 8'h01, 2'b00, 1'b1};
    tv[6]  = '{96'h080204210909090909090909, 8'h21, 8'h03, 8'h21, 8'h03, 8'd1, 8'hFF, 8'h05, 2'b10, 1'b0};
    tv[7]  = '{96'h08F003200130090909090909, 8'h20, 8'hF0, 8'h30, 8'h00, 8'd0, 8'h00, 8'h07, 2'b11, 1'b0};
    tv[8]  = '{96'h083C05210909090909090909, 8'h21, 8'h0F, 8'h21, 8'h0F, 8'd0, 8'h0C, 8'h05, 2'b00, 1'b0};
    tv[9]  = '{96'h08A502400800014009090909, 8'h40, 8'h00, 8'h40, 8'h00, 8'd2, 8'hA5, 8'h09, 2'b00, 1'b0};
    tv[10] = '{96'h000006080811090908220909, 8'h20, 8'h00, 8'h20, 8'h00, 8'd1, 8'h22, 8'h0B, 2'b00, 1'b0};
    for (int t = 0; t < 11; t++) begin
      load(tv[t]);
      n_reset = 1'b0;
      step(2);
      n_reset = 1'b1;
      wait_halt(cyc);
      chk($sformatf("v%0d halted", t), 32'(halted), 32'd1);
      chk($sformatf("v%0d acc", t), 32'(acc_out), 32'(tv[t].acc));
      chk($sformatf("v%0d pc", t), 32'(pc_out), 32'(tv[t].pc));
      chk($sformatf("v%0d flags", t), 32'(flags_out), 32'(tv[t].fl));
      chk($sformatf("v%0d illegal", t), 32'(illegal), 32'(tv[t].ill));
      ok = 0;
      repeat (5) begin
        step(1);
        ok += int'(mem_req);
      end
      chk($sformatf("v%0d idle_after_halt", t), 32'(ok), 32'd0);
    end
    load(tv[0]);
    n_reset = 1'b0;
    step(1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst acc", 32'(acc_out), 32'd0);
    chk("rst pc", 32'(pc_out), 32'd0);
    chk("rst flags", 32'(flags_out), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst ext_bus", 32'(ext_bus), 32'd0);
    step(1);
    chk("rst held mem_req", 32'(mem_req), 32'd0);
    n_reset = 1'b1;
    wait_halt(cyc);
    chk("ldi_hlt cycles", 32'(cyc), 32'd8);
    chk("ldi_hlt acc", 32'(acc_out), 32'h05);
    load('{96'h08A502400909090909090909, 8'h40, 8'h00, 8'h40, 8'h00, 8'd3, 8'h00, 8'h00, 2'b00, 1'b0});
    n_reset = 1'b0;
    step(2);
    n_reset = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 200) begin
      step(1);
      cyc++;
    end
    cyc = 0;
    ok = 0;
    while (mem_req && cyc < 20) begin
      if (mem_we && mem_addr == 8'h40 && mem_wdata == 8'hA5) ok++;
      step(1);
      cyc++;
    end
    chk("sta stable cycles", 32'(ok), 32'd4);
    chk("sta req cycles", 32'(cyc), 32'd4);
    chk("sta ext_bus", 32'(ext_bus), 32'hA5);
    chk("sta mem written", 32'(mem[8'h40]), 32'hA5);
    load(tv[5]);
    n_reset = 1'b0;
    step(2);
    n_reset = 1'b1;
    wait_halt(cyc);
    chk("ill illegal", 32'(illegal), 32'd1);
    n_reset = 1'b0;
    step(1);
    chk("ill rst illegal", 32'(illegal), 32'd0);
    chk("ill rst halted", 32'(halted), 32'd0);
    ws = 5;
    n_reset = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      step(1);
      cyc++;
    end
    step(2);
    chk("pending req", 32'(mem_req), 32'd1);
    n_reset = 1'b0;
    step(1);
    chk("pending rst mem_req", 32'(mem_req), 32'd0);
    chk("pending rst pc", 32'(pc_out), 32'd0);
    chk("pending rst illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 16; i++) mem4[i] = 8'h09;
    mem4[0] = 8'h06;
    mem4[1] = 8'h0F;
    mem4[15] = 8'h00;
    trace.delete();
    n_reset4 = 1'b1;
    cyc = 0;
    while (!halted4 && cyc < 100) begin
      step(1);
      cyc++;
    end
    chk("wrap halted", 32'(halted4), 32'd1);
    chk("wrap pc", 32'(pc4), 32'd2);
    chk("wrap illegal", 32'(illegal4), 32'd1);
    chk("wrap trace len", 32'(trace.size()), 32'd5);
    if (trace.size() == 5) begin
      chk("wrap trace", {12'd0, trace[0], trace[1], trace[2], trace[3], trace[4]}, 32'h0001F01);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
